// File: rtl/fp32_product_accumulator_pkg.sv
// Shared constants and types for the fp32 product accumulator.
// Field widths, exponent bias, guard-bit count, canonical NaN,
// signed infinities, max-finite values and the FSM state enum.
package fp32_product_accumulator_pkg;

  localparam int FP_EXP_W    = 8;
  localparam int FP_MAN_W    = 23;
  localparam int FP_BIAS     = 127;
  localparam int GUARD_BITS  = 3;
  // Aligned mantissa: hidden bit + fraction + guard bits.
  localparam int ALIGN_W     = FP_MAN_W + 1 + GUARD_BITS;

  localparam logic [31:0] FP_NAN     = 32'h7FC0_0000;
  localparam logic [31:0] FP_INF_POS = 32'h7F80_0000;
  localparam logic [31:0] FP_INF_NEG = 32'hFF80_0000;
  localparam logic [31:0] FP_MAX_POS = 32'h7F7F_FFFF;
  localparam logic [31:0] FP_MAX_NEG = 32'hFF7F_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_ADD   = 2'd2,
    ST_NORM  = 2'd3
  } state_t;

endpackage

// File: rtl/fp32_normalize.sv
// Leading-zero count plus normalizing shift for the accumulator sum.
// The sum is ALIGN_W+1 bits wide (carry bit on top). The result places
// the leading one at the hidden-bit position, truncating shifted-out bits,
// and reports the adjusted (possibly out-of-range) exponent.
module fp32_normalize
  import fp32_product_accumulator_pkg::*;
(
  input  logic [ALIGN_W:0]          sum,
  input  logic [FP_EXP_W-1:0]       exp_in,
  output logic                      zero,
  output logic [FP_MAN_W-1:0]       man,
  output logic signed [9:0]         exp_out
);

  logic [4:0]       lz;
  logic [ALIGN_W:0] norm;
  logic             norm_unused;

  // Count leading zeros from the carry bit down, then shift and adjust.
  always_comb begin
    lz = 5'd0;
    for (int i = 0; i <= ALIGN_W; i++) begin
      if (sum[i]) lz = 5'(ALIGN_W - i);
    end
    // lz == 0 means a carry out: one right shift; otherwise shift left.
    norm    = (lz == 5'd0) ? (sum >> 1) : (sum << (lz - 5'd1));
    man     = norm[ALIGN_W-2:GUARD_BITS];
    exp_out = $signed({2'b00, exp_in}) + 10'sd1 - $signed({5'b00000, lz});
    zero    = (sum == '0);
  end

  // Hidden bit, carry slot and guard bits are dropped on truncation.
  assign norm_unused = ^{norm[ALIGN_W:ALIGN_W-1], norm[GUARD_BITS-1:0]};

endmodule

// File: rtl/fp32_product_accumulator.sv
// fp32 product accumulator: adds a stream of fp32 terms into acc and emits
// the sum when a term marked last has been folded in. Each term walks a
// fixed IDLE -> ALIGN -> ADD -> NORM -> IDLE sequence (round toward zero,
// subnormals flushed). Define FP_ACC_SAT_EN to saturate exponent overflow
// to the signed max-finite value instead of producing signed Inf.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; valid and data hold steady until that edge, ready may change freely.
module fp32_product_accumulator
  import fp32_product_accumulator_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  state_t state_q, state_d;

  logic [31:0]        acc_q;
  logic [31:0]        term_q;
  logic               last_q;
  logic               out_valid_q;
  logic [31:0]        out_data_q;

  // ALIGN-stage results
  logic               big_sign_q;
  logic [7:0]         big_exp_q;
  logic [ALIGN_W-1:0] big_man_q;
  logic [ALIGN_W-1:0] small_man_q;
  logic               sub_q;
  logic               special_q;
  logic [31:0]        special_val_q;

  // ADD-stage result
  logic [ALIGN_W:0]   sum_q;

  logic accept;
  assign accept    = in_valid && in_ready;
  assign in_ready  = (state_q == ST_IDLE) && !out_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Next-state logic: one step per cycle once a term is accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ALIGN;
      ST_ALIGN: state_d = ST_ADD;
      ST_ADD:   state_d = ST_NORM;
      ST_NORM:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ALIGN: classify operands, order by magnitude, shift the smaller one.
  logic               a_nan, b_nan, a_inf, b_inf, swap, sub;
  logic [7:0]         a_e, b_e, big_e, small_e, diff;
  logic [23:0]        a_m, b_m, big_m, small_m;
  logic [ALIGN_W-1:0] small_al;
  logic               big_sign, special;
  logic [31:0]        special_val;

  always_comb begin
    a_e   = acc_q[30:23];
    b_e   = term_q[30:23];
    a_nan = (a_e == 8'hFF) && (acc_q[22:0] != 23'd0);
    b_nan = (b_e == 8'hFF) && (term_q[22:0] != 23'd0);
    a_inf = (a_e == 8'hFF) && (acc_q[22:0] == 23'd0);
    b_inf = (b_e == 8'hFF) && (term_q[22:0] == 23'd0);
    // Zero exponent (zero or subnormal) contributes a zero mantissa.
    a_m   = (a_e == 8'h00) ? 24'd0 : {1'b1, acc_q[22:0]};
    b_m   = (b_e == 8'h00) ? 24'd0 : {1'b1, term_q[22:0]};
    swap  = {b_e, b_m} > {a_e, a_m};
    big_sign = swap ? term_q[31] : acc_q[31];
    big_e    = swap ? b_e : a_e;
    big_m    = swap ? b_m : a_m;
    small_e  = swap ? a_e : b_e;
    small_m  = swap ? a_m : b_m;
    diff     = big_e - small_e;
    small_al = (diff >= 8'd27) ? '0 : ({small_m, 3'b000} >> diff);
    sub      = acc_q[31] ^ term_q[31];
    special     = 1'b0;
    special_val = FP_NAN;
    if (a_nan || b_nan) begin
      special = 1'b1;
    end else if (a_inf && b_inf && sub) begin
      special = 1'b1;
    end else if (a_inf) begin
      special     = 1'b1;
      special_val = acc_q;
    end else if (b_inf) begin
      special     = 1'b1;
      special_val = term_q;
    end
  end

  // ADD: magnitude add or subtract; big >= small so no borrow out.
  logic [ALIGN_W:0] sum_d;
  assign sum_d = sub_q ? ({1'b0, big_man_q} - {1'b0, small_man_q})
                       : ({1'b0, big_man_q} + {1'b0, small_man_q});

  // NORM: normalize and pack, handling cancellation, overflow, underflow.
  logic               n_zero;
  logic [22:0]        n_man;
  logic signed [9:0]  n_exp;
  logic [31:0]        ovf_val;
  logic [31:0]        result;

  fp32_normalize u_normalize (
    .sum     (sum_q),
    .exp_in  (big_exp_q),
    .zero    (n_zero),
    .man     (n_man),
    .exp_out (n_exp)
  );

`ifdef FP_ACC_SAT_EN
  assign ovf_val = big_sign_q ? FP_MAX_NEG : FP_MAX_POS;
`else
  assign ovf_val = big_sign_q ? FP_INF_NEG : FP_INF_POS;
`endif

  // Pack the normalized sum into fp32.
  always_comb begin
    result = {big_sign_q, n_exp[7:0], n_man};
    if (special_q)               result = special_val_q;
    else if (n_zero)             result = {big_sign_q & ~sub_q, 31'd0};
    else if (n_exp >= 10'sd255)  result = ovf_val;
    else if (n_exp <= 10'sd0)    result = {big_sign_q, 31'd0};
  end

  // Datapath, accumulator and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q         <= 32'd0;
      term_q        <= 32'd0;
      last_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 32'd0;
      big_sign_q    <= 1'b0;
      big_exp_q     <= 8'd0;
      big_man_q     <= '0;
      small_man_q   <= '0;
      sub_q         <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= 32'd0;
      sum_q         <= '0;
    end else begin
      if (accept) begin
        term_q <= in_data;
        last_q <= in_last;
      end
      if (state_q == ST_ALIGN) begin
        big_sign_q    <= big_sign;
        big_exp_q     <= big_e;
        big_man_q     <= {big_m, 3'b000};
        small_man_q   <= small_al;
        sub_q         <= sub;
        special_q     <= special;
        special_val_q <= special_val;
      end
      if (state_q == ST_ADD) sum_q <= sum_d;
      if (state_q == ST_NORM) begin
        acc_q <= result;
        if (last_q) begin
          out_valid_q <= 1'b1;
          out_data_q  <= result;
        end
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
        acc_q       <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_fp32_product_accumulator.sv
// Testbench for fp32_product_accumulator: directed sums with literal
// expected values plus randomized sums checked against an integer model.
module tb_fp32_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_val;
  logic [31:0] model_acc = 32'd0;
  bit          rand_ready = 1'b0;

  fp32_product_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, want);
    end
  endtask

  // Reference: fp32 add with truncation, 3 guard bits, no sticky, flush-to-zero.
  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    logic xs, ys, ts;
    int xe, ye, te, diff, e;
    longint xm, ym, tm, sm, s;
    xs = x[31]; ys = y[31];
    xe = int'(x[30:23]); ye = int'(y[30:23]);
    if ((xe == 255 && x[22:0] != 0) || (ye == 255 && y[22:0] != 0)) return 32'h7FC00000;
    if (xe == 255 && ye == 255 && xs != ys) return 32'h7FC00000;
    if (xe == 255) return x;
    if (ye == 255) return y;
    xm = (xe == 0) ? 64'd0 : longint'({1'b1, x[22:0]});
    ym = (ye == 0) ? 64'd0 : longint'({1'b1, y[22:0]});
    if (ye > xe || (ye == xe && ym > xm)) begin
      ts = xs; te = xe; tm = xm;
      xs = ys; xe = ye; xm = ym;
      ys = ts; ye = te; ym = tm;
    end
    diff = xe - ye;
    sm = (diff >= 27) ? 64'd0 : ((ym * 8) >> diff);
    s  = (xs == ys) ? (xm * 8 + sm) : (xm * 8 - sm);
    if (s == 0) return {(xs == ys) ? xs : 1'b0, 31'd0};
    e = xe;
    while (s >= 64'd134217728) begin s = s >> 1; e++; end
    while (s <  64'd67108864)  begin s = s << 1; e--; end
    if (e >= 255) begin
`ifdef FP_ACC_SAT_EN
      return xs ? 32'hFF7FFFFF : 32'h7F7FFFFF;
`else
      return xs ? 32'hFF800000 : 32'h7F800000;
`endif
    end
    if (e <= 0) return {xs, 31'd0};
    return {xs, 8'(e), 23'(s >> 3)};
  endfunction

  // one cycle; drives out_ready randomly when enabled
  task automatic tick();
    @(posedge clk); #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // driver: present one term, wait (bounded) for acceptance, update model
  task automatic send(input logic [31:0] d, input logic l);
    int guard;
    guard = 0;
    while (!in_ready && guard < 64) begin tick(); guard++; end
    check_val("in_ready_wait", 32'(in_ready), 32'd1);
    if (in_ready) begin
      in_valid = 1'b1; in_data = d; in_last = l;
      tick();
      in_valid = 1'b0; in_data = $urandom; in_last = 1'($urandom);
      model_acc = ref_add(model_acc, d);
      if (l) begin
        exp_q.push_back(model_acc);
        model_acc = 32'd0;
      end
    end
  endtask

  // pin the most recently queued sum to a literal value
  task automatic expect_last(input logic [31:0] lit);
    if (exp_q.size() != 0) exp_q[exp_q.size() - 1] = lit;
  endtask

  function automatic logic [31:0] rand_term();
    int sel;
    logic [31:0] r;
    sel = $urandom_range(0, 24);
    r = $urandom;
    case (sel)
      0: rand_term = {r[31], 31'd0};
      1: rand_term = {r[31], 8'd0, r[22:0]};
      2: rand_term = {r[31], 8'hFF, 23'd0};
      3: rand_term = {r[31], 8'hFF, 1'b1, r[21:0]};
      4: rand_term = {r[31], 8'd254, r[22:0]};
      5: rand_term = {r[31], 8'($urandom_range(1, 4)), r[22:0]};
      default: rand_term = {r[31], 8'($urandom_range(118, 136)), r[22:0]};
    endcase
  endfunction

  // scoreboard: compare every output handshake with the expected queue
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check_val("out_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_val = exp_q.pop_front();
        check_val("out_data", out_data, exp_val);
      end
    end
  end

  initial begin
    // reset
    rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_data", out_data, 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);

    // single term: latency and back-pressure hold
    out_ready = 1'b0;
    send(32'h3F800000, 1'b1);
    check_val("lat_busy", 32'(busy), 32'd1);
    check_val("lat_no_valid0", 32'(out_valid), 32'd0);
    repeat (2) begin
      tick();
      check_val("lat_no_valid", 32'(out_valid), 32'd0);
    end
    tick();
    check_val("lat_out_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_data = $urandom; in_last = 1'b1;
      tick();
      check_val("hold_data", out_data, 32'h3F800000);
      check_val("hold_valid", 32'(out_valid), 32'd1);
      check_val("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check_val("post_hs_valid", 32'(out_valid), 32'd0);
    check_val("post_hs_in_ready", 32'(in_ready), 32'd1);

    // directed sums
    send(32'h432B0000, 1'b0); send(32'hC4480000, 1'b1); expect_last(32'hC41D4000);
    send(32'h432B0000, 1'b0); send(32'hC32B0000, 1'b1); expect_last(32'h00000000);
    send(32'h4E800000, 1'b0); send(32'h3F800000, 1'b1); expect_last(32'h4E800000);
    send(32'h7F7FFFFF, 1'b0); send(32'h7F7FFFFF, 1'b1);
`ifdef FP_ACC_SAT_EN
    expect_last(32'h7F7FFFFF);
`else
    expect_last(32'h7F800000);
`endif
    send(32'hFF812345, 1'b0); send(32'h40000000, 1'b1); expect_last(32'h7FC00000);
    send(32'h7F800000, 1'b0); send(32'hFF800000, 1'b1); expect_last(32'h7FC00000);
    send(32'hFF800000, 1'b0); send(32'h3F800000, 1'b1); expect_last(32'hFF800000);
    send(32'h80000001, 1'b0); send(32'h00400000, 1'b1); expect_last(32'h00000000);
    send(32'h00800000, 1'b0); send(32'h80C00000, 1'b1); expect_last(32'h80000000);

    // reset while in ALIGN discards the term
    send(32'h40400000, 1'b0);
    check_val("align_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_acc = 32'd0;
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check_val("mid_rst_out_data", out_data, 32'd0);
    send(32'h40000000, 1'b1); expect_last(32'h40000000);

    // randomized sums with random back-pressure
    rand_ready = 1'b1;
    for (int s = 0; s < 40; s++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int t = 0; t < n; t++) begin
        repeat ($urandom_range(0, 2)) tick();
        send(rand_term(), (t == n - 1));
      end
    end

    // drain
    for (int k = 0; k < 200 && (exp_q.size() != 0 || busy || out_valid); k++) tick();
    check_val("drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
